// File: rtl/trig_wb_pkg.sv
// Shared types and decode helpers for the trigger-chain WISHBONE channel splitter.
package trig_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RSP_ACK = 2'd0,
    RSP_ERR = 2'd1,
    RSP_RTY = 2'd2
  } rsp_kind_e;

  function automatic logic [63:0] chan_index(input logic [63:0] adr,
                                             input int unsigned lsb,
                                             input int unsigned bits);
    logic [63:0] mask;
    mask = (64'd1 << bits) - 64'd1;
    return (adr >> lsb) & mask;
  endfunction

  function automatic logic [63:0] onehot(input logic [63:0] idx);
    return 64'd1 << idx;
  endfunction

endpackage

// File: rtl/trig_wb_watchdog.sv
// Wait-state watchdog: counts cycles while run_i is high and flags the TIMEOUT-th one.
module trig_wb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LIMIT = (TIMEOUT > 32'd0) ? TIMEOUT - 32'd1 : 32'd0;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_limit_s;

  assign at_limit_s = (cnt_q == CNT_W'(LIMIT));
  assign expire_o   = (TIMEOUT != 32'd0) && run_i && at_limit_s;

  // Count resets whenever the splitter is outside WAIT and parks at the limit.
  always_comb begin
    if (!run_i) begin
      cnt_d = '0;
    end else if (at_limit_s) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trigger_wb_chan_fanout.sv
// WISHBONE splitter: one upstream target fanned out to NCHAN channel register banks,
// with registered decode, broadcast writes, decode errors and a wait-state watchdog.
module trigger_wb_chan_fanout
  import trig_wb_pkg::*;
#(
  parameter int unsigned NCHAN      = 8,
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CHAN_ADR_W = 8,
  parameter int unsigned CHAN_LSB   = 10,
  parameter int unsigned BCAST_BIT  = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_ni,
  input  logic                           wb_cyc_i,
  input  logic                           wb_stb_i,
  input  logic                           wb_we_i,
  input  logic [ADDR_W-1:0]              wb_adr_i,
  input  logic [DATA_W-1:0]              wb_dat_i,
  input  logic [DATA_W/8-1:0]            wb_sel_i,
  output logic                           wb_ack_o,
  output logic                           wb_err_o,
  output logic                           wb_rty_o,
  output logic [DATA_W-1:0]              wb_dat_o,
  output logic [NCHAN-1:0]               m_cyc_o,
  output logic [NCHAN-1:0]               m_stb_o,
  output logic                           m_we_o,
  output logic [CHAN_ADR_W-1:0]          m_adr_o,
  output logic [DATA_W-1:0]              m_dat_o,
  output logic [DATA_W/8-1:0]            m_sel_o,
  input  logic [NCHAN-1:0]               m_ack_i,
  input  logic [NCHAN-1:0]               m_err_i,
  input  logic [NCHAN-1:0]               m_rty_i,
  input  logic [NCHAN-1:0][DATA_W-1:0]   m_dat_i,
  output logic [15:0]                    timeout_cnt_o
);

  localparam int unsigned SEL_W     = DATA_W / 8;
  localparam int unsigned CHAN_BITS = (NCHAN > 32'd1) ? $clog2(NCHAN) : 1;

  state_e                  state_q, state_d;
  logic [NCHAN-1:0]        pending_q, pending_d;
  logic                    err_acc_q, err_acc_d, rty_acc_q, rty_acc_d;
  logic                    we_q, we_d, bc_q, bc_d;
  logic [CHAN_BITS-1:0]    idx_q, idx_d;
  logic [CHAN_ADR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]       wdat_q, wdat_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    ack_q, ack_d, err_q, err_d, rty_q, rty_d;
  logic [DATA_W-1:0]       rdat_q, rdat_d;
  logic [15:0]             tocnt_q, tocnt_d;

  logic [63:0]             idx_s, oh_s;
  logic                    bc_s, dec_err_s, expire_s;
  logic [NCHAN-1:0]        hit_s, pend_nxt_s;
  logic                    err_any_s, rty_any_s;
  rsp_kind_e               kind_s;

  trig_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_ni),
    .run_i    (state_q == WAIT),
    .expire_o (expire_s)
  );

  assign wb_ack_o      = ack_q;
  assign wb_err_o      = err_q;
  assign wb_rty_o      = rty_q;
  assign wb_dat_o      = rdat_q;
  assign m_cyc_o       = pending_q;
  assign m_stb_o       = pending_q;
  assign m_we_o        = we_q;
  assign m_adr_o       = adr_q;
  assign m_dat_o       = wdat_q;
  assign m_sel_o       = sel_q;
  assign timeout_cnt_o = tocnt_q;

  // Decode, response collection and next-state selection.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    err_acc_d = err_acc_q;
    rty_acc_d = rty_acc_q;
    we_d      = we_q;
    bc_d      = bc_q;
    idx_d     = idx_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    sel_d     = sel_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rty_d     = 1'b0;
    rdat_d    = rdat_q;
    tocnt_d   = tocnt_q;

    idx_s     = chan_index(64'(wb_adr_i), CHAN_LSB, CHAN_BITS);
    oh_s      = onehot(idx_s);
    bc_s      = wb_adr_i[BCAST_BIT];
    dec_err_s = (bc_s && !wb_we_i) || (!bc_s && (idx_s >= 64'(NCHAN)));

    // Only channels still owed a response may retire; strays are masked off.
    hit_s      = pending_q & (m_ack_i | m_err_i | m_rty_i);
    pend_nxt_s = pending_q & ~hit_s;
    err_any_s  = err_acc_q || (|(pending_q & m_err_i));
    rty_any_s  = rty_acc_q || (|(pending_q & m_rty_i));
    if (err_any_s) begin
      kind_s = RSP_ERR;
    end else if (rty_any_s) begin
      kind_s = RSP_RTY;
    end else begin
      kind_s = RSP_ACK;
    end

    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          we_d   = wb_we_i;
          bc_d   = bc_s;
          idx_d  = idx_s[CHAN_BITS-1:0];
          adr_d  = wb_adr_i[CHAN_ADR_W-1:0];
          wdat_d = wb_dat_i;
          sel_d  = wb_sel_i;
          if (dec_err_s) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdat_d  = '0;
          end else begin
            state_d   = WAIT;
            pending_d = bc_s ? {NCHAN{1'b1}} : oh_s[NCHAN-1:0];
            err_acc_d = 1'b0;
            rty_acc_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d   = IDLE;
          pending_d = '0;
        end else if (pend_nxt_s == '0) begin
          state_d   = RESP;
          pending_d = '0;
          case (kind_s)
            RSP_ERR: begin
              err_d  = 1'b1;
              rdat_d = '0;
            end
            RSP_RTY: begin
              rty_d  = 1'b1;
              rdat_d = '0;
            end
            default: begin
              ack_d = 1'b1;
              if (!we_q) begin
                rdat_d = m_dat_i[idx_q];
              end else if (bc_q) begin
                rdat_d = '0;
              end else begin
                rdat_d = rdat_q;
              end
            end
          endcase
        end else if (expire_s) begin
          state_d   = RESP;
          pending_d = '0;
          err_d     = 1'b1;
          rdat_d    = '0;
          if (tocnt_q != 16'hFFFF) begin
            tocnt_d = tocnt_q + 16'd1;
          end else begin
            tocnt_d = tocnt_q;
          end
        end else begin
          pending_d = pend_nxt_s;
          err_acc_d = err_any_s;
          rty_acc_d = rty_any_s;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  // Transaction state, captured request fields and response registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      err_acc_q <= 1'b0;
      rty_acc_q <= 1'b0;
      we_q      <= 1'b0;
      bc_q      <= 1'b0;
      idx_q     <= '0;
      adr_q     <= '0;
      wdat_q    <= '0;
      sel_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rty_q     <= 1'b0;
      rdat_q    <= '0;
      tocnt_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      err_acc_q <= err_acc_d;
      rty_acc_q <= rty_acc_d;
      we_q      <= we_d;
      bc_q      <= bc_d;
      idx_q     <= idx_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rty_q     <= rty_d;
      rdat_q    <= rdat_d;
      tocnt_q   <= tocnt_d;
    end
  end

endmodule

// File: tb/tb_trigger_wb_chan_fanout.sv
// Self-checking bench for trigger_wb_chan_fanout (NCHAN=6, TIMEOUT=16): directed table,
// multi-cycle sequences and randomized transactions against a transaction-level model.
module tb_trigger_wb_chan_fanout;

  localparam int NCH = 6;
  localparam int T   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cyc, stb, we;
  logic [21:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic ack_o, err_o, rty_o;
  logic [31:0] dat_o;
  logic [NCH-1:0] m_cyc, m_stb, m_ack, m_err, m_rty;
  logic m_we;
  logic [7:0] m_adr;
  logic [31:0] m_dat;
  logic [3:0] m_sel;
  logic [NCH-1:0][31:0] m_rdat;
  logic [15:0] tocnt;

  int ch_lat[NCH];
  int ch_kind[NCH];
  logic [31:0] ch_rdat[NCH];
  int cnt[NCH];
  logic [NCH-1:0] nz_ack = '0, nz_err = '0, nz_rty = '0;

  int tests = 0;
  int fails = 0;
  int exp_to = 0;
  logic [31:0] hold = 32'd0;

  always #5 clk = ~clk;

  trigger_wb_chan_fanout #(.NCHAN(NCH), .TIMEOUT(T)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_ack_o(ack_o), .wb_err_o(err_o),
    .wb_rty_o(rty_o), .wb_dat_o(dat_o), .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we),
    .m_adr_o(m_adr), .m_dat_o(m_dat), .m_sel_o(m_sel), .m_ack_i(m_ack), .m_err_i(m_err),
    .m_rty_i(m_rty), .m_dat_i(m_rdat), .timeout_cnt_o(tocnt)
  );

  // Channel responders: respond after ch_lat cycles of strobe; idle channels emit noise.
  always @(posedge clk) begin
    for (int j = 0; j < NCH; j++) cnt[j] <= m_stb[j] ? cnt[j] + 1 : 0;
  end

  always_comb begin
    m_ack = '0; m_err = '0; m_rty = '0; m_rdat = '0;
    for (int j = 0; j < NCH; j++) begin
      m_rdat[j] = ch_rdat[j];
      if (m_stb[j]) begin
        if (cnt[j] == ch_lat[j]) begin
          m_ack[j] = (ch_kind[j] == 1);
          m_err[j] = (ch_kind[j] == 2);
          m_rty[j] = (ch_kind[j] == 3);
        end
      end else begin
        m_ack[j] = nz_ack[j];
        m_err[j] = nz_err[j];
        m_rty[j] = nz_rty[j];
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Response codes: 0 none, 1 ack, 2 err, 3 rty, 7 malformed.
  task automatic run_txn(input logic [21:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                         input int abort_at, input int ek, input int en, input logic [31:0] ed,
                         input int to_inc, input string nm);
    logic [NCH-1:0] tgt;
    logic [2:0] p;
    logic e;
    int idx, wend, last_n, obs_k, obs_n, stb_bad;
    idx = int'(a[12:10]);
    tgt = '0;
    if (a[16]) tgt = w ? '1 : '0;
    else if (idx < NCH) tgt[idx] = 1'b1;
    wend   = (ek == 0) ? abort_at : en - 1;
    last_n = (ek == 0) ? abort_at + 6 : en + 1;
    obs_k = 0; obs_n = 0; stb_bad = 0;
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; wdat = d; sel = s;
    for (int n = 1; n <= last_n; n++) begin
      @(posedge clk); #1;
      for (int j = 0; j < NCH; j++) begin
        e = tgt[j] && (n <= wend) && (n <= ch_lat[j] + 1);
        if (m_stb[j] !== e || m_cyc[j] !== e) stb_bad++;
      end
      p = {ack_o, err_o, rty_o};
      if (p != 3'b000) begin
        if (obs_k != 0) obs_k = 7;
        else begin
          obs_n = n;
          obs_k = (p == 3'b100) ? 1 : (p == 3'b010) ? 2 : (p == 3'b001) ? 3 : 7;
        end
      end
      if (n == 1 && tgt != '0)
        check({nm, " shared"}, 64'({m_we, m_adr, m_sel, m_dat}), 64'({w, a[7:0], s, d}));
      if (ek != 0 && n == en) check({nm, " dat"}, 64'(dat_o), 64'(ed));
      if (n == en || (ek == 0 && n == abort_at)) begin
        cyc = 1'b0; stb = 1'b0;
      end
      nz_ack = NCH'($urandom); nz_err = NCH'($urandom); nz_rty = NCH'($urandom);
    end
    check({nm, " rsp"}, 64'(obs_k * 256 + obs_n), 64'(ek * 256 + en));
    check({nm, " stb"}, 64'(stb_bad), 64'd0);
    exp_to += to_inc;
    check({nm, " tocnt"}, 64'(tocnt), 64'(exp_to));
    if (ek != 0) hold = ed;
  endtask

  // Transaction-level reference: whole-transaction outcome from channel latencies and kinds.
  task automatic model(input logic [21:0] a, input logic w, input int abort_at,
                       output int ek, output int en, output int to_inc, output logic [31:0] ed);
    int idx, c, term;
    bit tmo, anyerr, anyrty;
    idx = int'(a[12:10]);
    ek = 0; en = 0; to_inc = 0; ed = hold;
    if ((a[16] && !w) || (!a[16] && idx >= NCH)) begin
      ek = 2; en = 1; ed = 32'd0;
      return;
    end
    c = 0; anyerr = 0; anyrty = 0;
    for (int j = 0; j < NCH; j++) begin
      if (a[16] || j == idx) begin
        if (ch_lat[j] + 1 > c) c = ch_lat[j] + 1;
        anyerr |= (ch_kind[j] == 2);
        anyrty |= (ch_kind[j] == 3);
      end
    end
    tmo  = c > T;
    term = tmo ? T : c;
    if (abort_at > 0 && abort_at <= term) return;
    en = term + 1;
    if (tmo) begin ek = 2; ed = 32'd0; to_inc = 1; end
    else if (anyerr) begin ek = 2; ed = 32'd0; end
    else if (anyrty) begin ek = 3; ed = 32'd0; end
    else begin
      ek = 1;
      ed = w ? (a[16] ? 32'd0 : hold) : ch_rdat[idx];
    end
  endtask

  typedef struct {
    logic [21:0] adr; logic we; logic [31:0] wdat;
    int base; int skew; int err_ch; int rty_ch; int abort_at;
    int ek; int en; logic [31:0] ed; int to;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [21:0] ra;
    logic rw;
    int ab, ek, en, ti;
    logic [31:0] ed;

    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
    for (int j = 0; j < NCH; j++) begin
      ch_lat[j] = 0; ch_kind[j] = 1; ch_rdat[j] = 32'hC0DE_0000 + 32'(j);
    end
    ch_rdat[5] = 32'hDEADBEEF;

    #2;
    check("reset ctl", 64'({ack_o, err_o, rty_o, m_we, m_cyc, m_stb, m_sel, m_adr}), 64'd0);
    check("reset dat", 64'({dat_o, m_dat}), 64'd0);
    check("reset tocnt", 64'(tocnt), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    //          adr       we    wdat          base skew err rty abort ek en ed             to
    tbl[0]  = '{22'h01404, 1'b0, 32'h0,        0,   0,  -1, -1, 0,    1, 2,  32'hDEADBEEF, 0};
    tbl[1]  = '{22'h00033, 1'b1, 32'hAAAA5555, 2,   0,  -1, -1, 0,    1, 4,  32'hDEADBEEF, 0};
    tbl[2]  = '{22'h10000, 1'b1, 32'h12345678, 0,   1,  -1, -1, 0,    1, 7,  32'h0,        0};
    tbl[3]  = '{22'h01C00, 1'b0, 32'h0,        0,   0,  -1, -1, 0,    2, 1,  32'h0,        0};
    tbl[4]  = '{22'h10000, 1'b0, 32'h0,        0,   0,  -1, -1, 0,    2, 1,  32'h0,        0};
    tbl[5]  = '{22'h10055, 1'b1, 32'h0BADF00D, 1,   0,   3,  1, 0,    2, 3,  32'h0,        0};
    tbl[6]  = '{22'h00400, 1'b0, 32'h0,        0,   0,  -1,  1, 0,    3, 2,  32'h0,        0};
    tbl[7]  = '{22'h01000, 1'b0, 32'h0,        100, 0,  -1, -1, 3,    0, 0,  32'h0,        0};
    tbl[8]  = '{22'h00C08, 1'b0, 32'h0,        15,  0,  -1, -1, 0,    1, 17, 32'hC0DE0003, 0};
    tbl[9]  = '{22'h00810, 1'b0, 32'h0,        16,  0,  -1, -1, 0,    2, 17, 32'h0,        1};
    tbl[10] = '{22'h01800, 1'b1, 32'h1,        0,   0,  -1, -1, 0,    2, 1,  32'h0,        0};

    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < NCH; j++) begin
        ch_lat[j]  = tbl[i].base + j * tbl[i].skew;
        ch_kind[j] = (j == tbl[i].err_ch) ? 2 : (j == tbl[i].rty_ch) ? 3 : 1;
      end
      run_txn(tbl[i].adr, tbl[i].we, tbl[i].wdat, 4'hF, tbl[i].abort_at, tbl[i].ek, tbl[i].en,
              tbl[i].ed, tbl[i].to, $sformatf("vec%0d", i));
    end

    // Two more watchdog expiries on a silent channel.
    for (int j = 0; j < NCH; j++) begin ch_lat[j] = 100; ch_kind[j] = 1; end
    for (int r = 0; r < 2; r++) run_txn(22'h00800, 1'b0, 32'h0, 4'h1, 0, 2, 17, 32'h0, 1, $sformatf("tmo%0d", r));
    check("tocnt three", 64'(tocnt), 64'd3);

    // Asynchronous reset in the middle of a WAIT.
    ch_lat[5] = 0;
    run_txn(22'h01404, 1'b0, 32'h0, 4'hF, 0, 1, 2, 32'hDEADBEEF, 0, "pre_rst");
    cyc = 1'b1; stb = 1'b1; adr = 22'h00877; we = 1'b1; wdat = 32'h5A5A5A5A; sel = 4'hF;
    @(posedge clk); #1;
    check("rst pre stb", 64'(m_stb), 64'(6'b000100));
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst async ctl", 64'({ack_o, err_o, rty_o, m_we, m_cyc, m_stb, m_sel, m_adr}), 64'd0);
    check("rst async dat", 64'({dat_o, m_dat}), 64'd0);
    check("rst async tocnt", 64'(tocnt), 64'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_to = 0; hold = 32'd0;
    run_txn(22'h01404, 1'b0, 32'h0, 4'hF, 0, 1, 2, 32'hDEADBEEF, 0, "post_rst");

    // Randomized transactions against the reference model.
    for (int i = 0; i < 60; i++) begin
      ra = 22'($urandom);
      ra[12:10] = 3'($urandom_range(0, 7));
      ra[16] = ($urandom_range(0, 3) == 0);
      rw = 1'($urandom);
      for (int j = 0; j < NCH; j++) begin
        ch_lat[j]  = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(0, 4);
        ch_kind[j] = ($urandom_range(0, 9) == 0) ? 2 : ($urandom_range(0, 9) == 0) ? 3 : 1;
      end
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
      model(ra, rw, ab, ek, en, ti, ed);
      run_txn(ra, rw, 32'($urandom), 4'($urandom), ab, ek, en, ed, ti, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
